// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Sits between register-file read and writeback/status. Single-cycle ops
// (ADD, SUB, AND, NOT, OR, XOR, ASR) produce a result one cycle after
// accept; MUL runs a WIDTH-step shift-and-add and produces its result
// WIDTH+1 cycles after accept. The result and flags stay registered until
// the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   op/operands presented
//   in_ready   op can be accepted this cycle
//   Ain, Bin   operands (WIDTH bits)
//   ALUop      operation select (3 bits)
//   out        registered result
//   Z          registered flags {V,N,Z}
//   out_valid  out/Z hold an unconsumed result
//   out_ready  consumer takes the result this cycle
//   busy       multiply in progress
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       Z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int MSB = WIDTH - 1;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_out;
    logic [2:0]         r_flags;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_last;
    logic [WIDTH-1:0]   w_res;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mul_res;

    // A finished result can be retired and replaced on the same edge, so
    // DONE with out_ready behaves like IDLE for acceptance.
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (ALUop == OP_MUL);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    assign out       = r_out;
    assign Z         = r_flags;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL);

    // One shift-and-add step; on the final step this value is the product.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_res  = w_acc_next[WIDTH-1:0];

    // Single-cycle datapath, evaluated on the live inputs at accept time.
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                w_res = Ain + Bin;
                w_v   = (Ain[MSB] == Bin[MSB]) && (w_res[MSB] != Ain[MSB]);
            end
            OP_SUB: begin
                w_res = Ain - Bin;
                w_v   = (Ain[MSB] != Bin[MSB]) && (w_res[MSB] != Ain[MSB]);
            end
            OP_AND:  w_res = Ain & Bin;
            OP_NOT:  w_res = ~Bin;
            OP_OR:   w_res = Ain | Bin;
            OP_XOR:  w_res = Ain ^ Bin;
            OP_ASR:  w_res = {Bin[MSB], Bin[MSB:1]};
            default: w_res = '0;  // MUL result comes from the iterative path
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_flags  <= 3'b000;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_mcand  <= {{WIDTH{1'b0}}, Ain};
                            r_mplier <= Bin;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_out   <= w_res;
                            r_flags <= {w_v, w_res[MSB], (w_res == '0)};
                            r_state <= S_DONE;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out   <= w_mul_res;
                        // Overflow means any product bit above the kept width.
                        r_flags <= {(w_acc_next[2*WIDTH-1:WIDTH] != '0),
                                    w_mul_res[MSB], (w_mul_res == '0)};
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc (WIDTH=16).
// Directed scenarios followed by randomized ops checked against an
// arithmetic reference model. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic [2:0]   ALUop;
    logic [W-1:0] out;
    logic [2:0]   Z;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out       (out),
        .Z         (Z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic [2:0] f);
        int              sa, sb, s;
        longint unsigned p;
        logic            v;
        logic signed [W-1:0] bs;
        sa = int'($signed(a));
        sb = int'($signed(b));
        bs = b;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin s = sa + sb; r = W'(s); v = (s > 2**(W-1) - 1) || (s < -(2**(W-1))); end
            3'd1: begin s = sa - sb; r = W'(s); v = (s > 2**(W-1) - 1) || (s < -(2**(W-1))); end
            3'd2: r = a & b;
            3'd3: r = ~b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = W'(bs >>> 1);
            default: begin
                p = longint'(a) * longint'(b);
                r = W'(p);
                v = ((p >> W) != 0);
            end
        endcase
        f = {v, r[W-1], (r == '0)};
    endfunction

    // Issue one op from IDLE, wait for the result, check latency, busy time,
    // result and flags, optionally hold, then consume it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic [2:0]   ef;
        int           lat, bc;
        model(op, a, b, er, ef);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        Ain = a; Bin = b; ALUop = op; in_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs after accept: they must not affect the result.
        in_valid = 1'b0; Ain = W'($urandom); Bin = W'($urandom); ALUop = 3'($urandom);
        lat = 1; bc = 0;
        while (!out_valid && lat < 64) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, (op == 3'd7) ? W + 1 : 1);
        chk({tag, "_busy_cycles"}, bc, (op == 3'd7) ? W : 0);
        chk({tag, "_out"}, out, er);
        chk({tag, "_flags"}, Z, ef);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({tag, "_held_out"}, out, er);
            chk({tag, "_held_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_consumed"}, out_valid, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Ain = '0; Bin = '0; ALUop = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_flags", Z, 3'b000);
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        Ain = 16'h0012; Bin = 16'h0034; ALUop = 3'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midmul_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("midmul_rst_out", out, 0);
        chk("midmul_rst_flags", Z, 3'b000);
        chk("midmul_rst_valid", out_valid, 0);
        chk("midmul_rst_in_ready", in_ready, 1);
        chk("midmul_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // ADD overflow, then back-to-back ASR with no idle bubble.
        @(negedge clk);
        Ain = 16'h7FFF; Bin = 16'h0001; ALUop = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("add_ovf_valid", out_valid, 1);
        chk("add_ovf_out", out, 16'h8000);
        chk("add_ovf_flags", Z, 3'b110);
        out_ready = 1'b1; in_valid = 1'b1; ALUop = 3'd6; Ain = 16'h5555; Bin = 16'h8004;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_out", out, 16'hC002);
        chk("b2b_flags", Z, 3'b010);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_consumed", out_valid, 0);

        // SUB to zero, then hold with out_ready low while a new op waits.
        @(negedge clk);
        Ain = 16'h1234; Bin = 16'h1234; ALUop = 3'd1; in_valid = 1'b1;
        @(negedge clk);
        ALUop = 3'd0; Ain = 16'h0F0F; Bin = 16'h0101;  // stays pending, must not be taken
        for (int i = 0; i < 5; i++) begin
            chk("sub_hold_out", out, 0);
            chk("sub_hold_flags", Z, 3'b001);
            chk("sub_hold_valid", out_valid, 1);
            chk("sub_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("sub_consumed", out_valid, 0);

        // Multiply timing and overflow.
        run_op("mul_timing", 3'd7, 16'h0012, 16'h0034, 0);
        run_op("mul_ovf", 3'd7, 16'h0100, 16'h0100, 2);
        run_op("mul_max", 3'd7, 16'hFFFF, 16'hFFFF, 0);
        run_op("sub_ovf", 3'd1, 16'h8000, 16'h0001, 0);

        // Randomized ops.
        for (int i = 0; i < 60; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
